// File: rtl/intra_pred_line_ram.sv
// Intra-prediction line buffer: one luma and two chroma word RAMs with registered
// write-through reads, range checking against the picture width, and a row clear sequencer.
module intra_pred_line_ram #(
  parameter int unsigned MB_X_BITS = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [MB_X_BITS-1:0]   pic_width_in_mbs_minus1,
  input  logic                   clear_start,
  input  logic [MB_X_BITS+1:0]   line_ram_luma_addr,
  input  logic [MB_X_BITS:0]     line_ram_chroma_addr,
  input  logic                   line_ram_luma_wr_n,
  input  logic                   line_ram_cb_wr_n,
  input  logic                   line_ram_cr_wr_n,
  input  logic [31:0]            luma_wdata,
  input  logic [31:0]            cb_wdata,
  input  logic [31:0]            cr_wdata,
  output logic [31:0]            line_ram_luma_data,
  output logic [31:0]            line_ram_cb_data,
  output logic [31:0]            line_ram_cr_data,
  output logic                   busy,
  output logic                   clear_done,
  output logic                   addr_err
);

  localparam int unsigned LW    = MB_X_BITS + 2;
  localparam int unsigned CW    = MB_X_BITS + 1;
  localparam int unsigned LIM_W = MB_X_BITS + 3;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_nx;
  logic [LW-1:0]    cnt, cnt_nx;
  logic [LIM_W-1:0] mbs, luma_lim, chroma_lim;
  logic             luma_ok, chroma_ok, cnt_in_chroma, cnt_last;

  logic [31:0] luma_mem [0:(1<<LW)-1];
  logic [31:0] cb_mem   [0:(1<<CW)-1];
  logic [31:0] cr_mem   [0:(1<<CW)-1];

  logic          luma_we, cb_we, cr_we, err_set, done_nx;
  logic [LW-1:0] luma_wa;
  logic [CW-1:0] chroma_wa;
  logic [31:0]   luma_wd, cb_wd, cr_wd;

  assign mbs        = {3'b000, pic_width_in_mbs_minus1} + 1'b1;
  assign luma_lim   = {mbs[LIM_W-3:0], 2'b00};
  assign chroma_lim = {mbs[LIM_W-2:0], 1'b0};

  assign luma_ok       = {1'b0, line_ram_luma_addr}    < luma_lim;
  assign chroma_ok     = {2'b00, line_ram_chroma_addr} < chroma_lim;
  assign cnt_in_chroma = {1'b0, cnt} < chroma_lim;
  assign cnt_last      = {1'b0, cnt} == (luma_lim - 1'b1);

  assign busy = (state == CLEAR);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    luma_we   = 1'b0;
    cb_we     = 1'b0;
    cr_we     = 1'b0;
    luma_wa   = line_ram_luma_addr;
    chroma_wa = line_ram_chroma_addr;
    luma_wd   = luma_wdata;
    cb_wd     = cb_wdata;
    cr_wd     = cr_wdata;
    err_set   = 1'b0;
    done_nx   = 1'b0;
    if (ena) begin
      case (state)
        IDLE: begin
          luma_we = !line_ram_luma_wr_n && luma_ok;
          cb_we   = !line_ram_cb_wr_n   && chroma_ok;
          cr_we   = !line_ram_cr_wr_n   && chroma_ok;
          err_set = (!line_ram_luma_wr_n && !luma_ok) ||
                    ((!line_ram_cb_wr_n || !line_ram_cr_wr_n) && !chroma_ok);
          if (clear_start) begin
            state_nx = CLEAR;
            cnt_nx   = '0;
          end
        end
        CLEAR: begin
          luma_wa   = cnt;
          chroma_wa = cnt[CW-1:0];
          luma_wd   = '0;
          cb_wd     = '0;
          cr_wd     = '0;
          luma_we   = 1'b1;
          cb_we     = cnt_in_chroma;
          cr_we     = cnt_in_chroma;
          if (cnt_last) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (luma_we) luma_mem[luma_wa] <= luma_wd;
    if (cb_we)   cb_mem[chroma_wa] <= cb_wd;
    if (cr_we)   cr_mem[chroma_wa] <= cr_wd;
  end

  // Outputs read zero for the whole clear, including the edge that starts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      addr_err           <= 1'b0;
      clear_done         <= 1'b0;
      line_ram_luma_data <= '0;
      line_ram_cb_data   <= '0;
      line_ram_cr_data   <= '0;
    end else begin
      clear_done <= done_nx;
      if (ena) begin
        state <= state_nx;
        cnt   <= cnt_nx;
        if (err_set) addr_err <= 1'b1;
        if (state == CLEAR || clear_start) begin
          line_ram_luma_data <= '0;
          line_ram_cb_data   <= '0;
          line_ram_cr_data   <= '0;
        end else begin
          line_ram_luma_data <= !luma_ok ? '0 :
                                (!line_ram_luma_wr_n ? luma_wdata : luma_mem[line_ram_luma_addr]);
          line_ram_cb_data   <= !chroma_ok ? '0 :
                                (!line_ram_cb_wr_n ? cb_wdata : cb_mem[line_ram_chroma_addr]);
          line_ram_cr_data   <= !chroma_ok ? '0 :
                                (!line_ram_cr_wr_n ? cr_wdata : cr_mem[line_ram_chroma_addr]);
        end
      end
    end
  end

endmodule

// File: tb/tb_intra_pred_line_ram.sv
// Scoreboard bench for intra_pred_line_ram: a reference model predicts every cycle's
// outputs into a queue that an independent monitor drains and compares.
module tb_intra_pred_line_ram;

  localparam int unsigned MXB = 7;
  localparam int unsigned LL  = 16;
  localparam int unsigned CL  = 8;

  logic        clk = 1'b0, rst = 1'b1, ena = 1'b0, clear_start = 1'b0;
  logic [6:0]  pic_w = 7'd3;
  logic [8:0]  luma_addr = '0;
  logic [7:0]  chroma_addr = '0;
  logic        luma_wr_n = 1'b1, cb_wr_n = 1'b1, cr_wr_n = 1'b1;
  logic [31:0] luma_wd = '0, cb_wd = '0, cr_wd = '0;
  logic [31:0] luma_q, cb_q, cr_q;
  logic        busy, clear_done, addr_err;

  always #5 clk = ~clk;

  intra_pred_line_ram #(.MB_X_BITS(MXB)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .pic_width_in_mbs_minus1(pic_w),
    .clear_start(clear_start),
    .line_ram_luma_addr(luma_addr),
    .line_ram_chroma_addr(chroma_addr),
    .line_ram_luma_wr_n(luma_wr_n),
    .line_ram_cb_wr_n(cb_wr_n),
    .line_ram_cr_wr_n(cr_wr_n),
    .luma_wdata(luma_wd), .cb_wdata(cb_wd), .cr_wdata(cr_wd),
    .line_ram_luma_data(luma_q),
    .line_ram_cb_data(cb_q),
    .line_ram_cr_data(cr_q),
    .busy(busy), .clear_done(clear_done), .addr_err(addr_err)
  );

  typedef struct packed {
    logic [31:0] l, cb, cr;
    logic        busy, done, err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain word arrays plus "clear in progress, next word to zero".
  logic [31:0] ml [0:511];
  logic [31:0] mc [0:255];
  logic [31:0] mr [0:255];
  bit          m_busy = 0;
  bit          m_err  = 0;
  int          m_pos  = 0;
  logic [31:0] el = '0, ecb = '0, ecr = '0;

  task automatic model_edge();
    bit   done;
    int   la, ca;
    exp_t e;
    done = 0;
    la = int'(luma_addr);
    ca = int'(chroma_addr);
    if (rst) begin
      m_busy = 0; m_pos = 0; m_err = 0;
      el = '0; ecb = '0; ecr = '0;
    end else if (ena) begin
      if (m_busy) begin
        el = '0; ecb = '0; ecr = '0;
        ml[m_pos] = '0;
        if (m_pos < CL) begin mc[m_pos] = '0; mr[m_pos] = '0; end
        m_pos++;
        if (m_pos == LL) begin m_busy = 0; done = 1; end
      end else begin
        el  = (la >= LL) ? '0 : (!luma_wr_n ? luma_wd : ml[la]);
        ecb = (ca >= CL) ? '0 : (!cb_wr_n ? cb_wd : mc[ca]);
        ecr = (ca >= CL) ? '0 : (!cr_wr_n ? cr_wd : mr[ca]);
        if (!luma_wr_n) begin if (la < LL) ml[la] = luma_wd; else m_err = 1; end
        if (!cb_wr_n)   begin if (ca < CL) mc[ca] = cb_wd;   else m_err = 1; end
        if (!cr_wr_n)   begin if (ca < CL) mr[ca] = cr_wd;   else m_err = 1; end
        if (clear_start) begin
          m_busy = 1; m_pos = 0;
          el = '0; ecb = '0; ecr = '0;
        end
      end
    end
    e.l = el; e.cb = ecb; e.cr = ecr;
    e.busy = m_busy; e.done = done; e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit en, input bit cs,
                     input bit lwn, input bit cbwn, input bit crwn,
                     input int la, input int ca,
                     input logic [31:0] lw, input logic [31:0] cbw, input logic [31:0] crw);
    @(posedge clk);
    #2;
    rst = r; ena = en; clear_start = cs;
    luma_wr_n = lwn; cb_wr_n = cbwn; cr_wr_n = crwn;
    luma_addr = la[8:0]; chroma_addr = ca[7:0];
    luma_wd = lw; cb_wd = cbw; cr_wd = crw;
    model_edge();
  endtask

  task automatic rd(input int la, input int ca);
    cyc(0, 1, 0, 1, 1, 1, la, ca, $urandom, $urandom, $urandom);
  endtask

  task automatic sweep();
    for (int i = 0; i < int'(LL); i++) rd(i, i % int'(CL));
  endtask

  task automatic fill();
    for (int i = 0; i < int'(LL); i++)
      cyc(0, 1, 0, 0, (i >= int'(CL)), (i >= int'(CL)), i, i % int'(CL),
          $urandom | 32'h1, $urandom | 32'h100, $urandom | 32'h10000);
  endtask

  task automatic drain_clear();
    for (int k = 0; k < 40 && m_busy; k++) rd(0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("luma_data",  luma_q, e.l);
        chk("cb_data",    cb_q,   e.cb);
        chk("cr_data",    cr_q,   e.cr);
        chk("busy",       {31'd0, busy},       {31'd0, e.busy});
        chk("clear_done", {31'd0, clear_done}, {31'd0, e.done});
        chk("addr_err",   {31'd0, addr_err},   {31'd0, e.err});
      end
    end
  end

  initial begin : driver
    cyc(1, 0, 0, 1, 1, 1, 0, 0, '0, '0, '0);
    cyc(1, 1, 1, 0, 0, 0, 3, 3, '1, '1, '1);
    fill();

    // Directed writes, write-through and out-of-range handling
    cyc(0, 1, 0, 0, 1, 1, 5, 0, 32'hA1B2C3D4, '0, '0);
    rd(5, 0);
    cyc(0, 1, 0, 1, 0, 1, 0, 2, '0, 32'h11223344, 32'hDEADBEEF);
    rd(0, 2);
    cyc(0, 1, 0, 0, 1, 1, 16, 0, 32'hFFFFFFFF, '0, '0);
    rd(16, 8);
    sweep();

    for (int n = 0; n < 400; n++) begin
      int la, ca;
      la = ($urandom % 16 == 0) ? int'($urandom % 512) : int'($urandom % 20);
      ca = ($urandom % 16 == 0) ? int'($urandom % 256) : int'($urandom % 10);
      cyc(0, ($urandom % 8) != 0, ($urandom % 60) == 0,
          $urandom % 2, $urandom % 2, $urandom % 2, la, ca,
          $urandom, $urandom, $urandom);
    end
    drain_clear();

    // Full clear of non-zero contents
    fill();
    cyc(0, 1, 1, 1, 1, 1, 0, 0, '0, '0, '0);
    for (int k = 0; k < 18; k++) rd(k % 20, k % 10);
    sweep();

    // Clear stalled by ena low at cnt 7
    fill();
    cyc(0, 1, 1, 1, 1, 1, 0, 0, '0, '0, '0);
    for (int k = 0; k < 7; k++) rd(1, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0, 0, 0, 2, 2, '1, '1, '1);
    for (int k = 0; k < 12; k++) rd(3, 3);
    sweep();

    // clear_start coincident with a write, then reset aborting at cnt 4
    fill();
    cyc(0, 1, 1, 0, 1, 1, 9, 0, 32'h5A5A0009, '0, '0);
    for (int k = 0; k < 4; k++) rd(4, 4);
    cyc(1, 1, 0, 1, 1, 1, 4, 4, '0, '0, '0);
    rd(4, 4);
    sweep();

    cyc(0, 1, 0, 1, 1, 1, 0, 0, '0, '0, '0);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
